pcileech_com_rx_packer: RTL and testbench

PCILEECH_COM_RX_PACKER -- requirements
Module: pcileech_com_rx_packer

---
 rtl/pcileech_com_pkg.sv | 14 +
 rtl/pcileech_com_init_rom.sv | 17 +
 rtl/pcileech_com_rx_packer.sv | 173 +++++++++++++++++
 tb/tb_pcileech_com_rx_packer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcileech_com_pkg.sv
// Shared types and constants for the PCILeech COM receive path.
package pcileech_com_pkg;

   // Packer control states
   typedef enum logic [1:0] {
      ST_WAIT = 2'd0,
      ST_BOOT = 2'd1,
      ST_RUN  = 2'd2
   } rxpack_state_t;

   // Default beat pattern; two in a row form a resync marker
   localparam logic [31:0] COM_RESYNC_WORD = 32'h66665555;

endpackage

// File: rtl/pcileech_com_init_rom.sv
// Boot table for the COM receive packer: word N holds the value N for
// N < DEPTH, zero beyond. Combinational read, instantiated beside the packer.
module pcileech_com_init_rom #(
   parameter int unsigned OUT_W = 64,
   parameter int unsigned DEPTH = 6
) (
   input  logic [5:0]       addr,
   output logic [OUT_W-1:0] data
);

   // Same-cycle table lookup
   always_comb begin
      data = '0;
      if (32'(addr) < DEPTH) data = OUT_W'(addr);
   end

endmodule

// File: rtl/pcileech_com_rx_packer.sv
// COM receive packer: after reset waits INIT_DELAY cycles, replays
// INIT_DEPTH boot words from an external table, then packs RATIO input
// beats MSB-first into OUT_W-bit output words with resync detection.
// Optional macro COM_RXPACK_TIMEOUT_EN enables discarding of stale
// partial words after TIMEOUT idle cycles.
module pcileech_com_rx_packer
   import pcileech_com_pkg::*;
#(
   parameter int unsigned     IN_W        = 32,
   parameter int unsigned     RATIO       = 2,
   parameter int unsigned     INIT_DEPTH  = 6,
   parameter int unsigned     INIT_DELAY  = 16,
   parameter logic [IN_W-1:0] RESYNC_WORD = IN_W'(COM_RESYNC_WORD),
   parameter int unsigned     TIMEOUT     = 1024,
   localparam int unsigned    OUT_W       = IN_W * RATIO
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IN_W-1:0]  in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [5:0]       init_addr,
   input  logic [OUT_W-1:0] init_data,
   output logic             boot_done,
   output logic [7:0]       resync_cnt,
   output logic [7:0]       drop_cnt
);

   rxpack_state_t    state, state_nx;
   logic [31:0]      dly_cnt;
   logic [5:0]       addr;
   logic             boot_done_r;
   logic [OUT_W-1:0] acc, acc_nx, oreg;
   logic             ovalid;
   logic [31:0]      beat_cnt;
   logic             held;
   logic [7:0]       rs_cnt;
   logic             delay_done, boot_last, can_load, is_rsw;
   logic             accept, flush, resync, shift, word_done, partial, drop;
   logic [IN_W-1:0]  beat;

   assign delay_done = (INIT_DELAY == 0) || (dly_cnt == INIT_DELAY - 1);
   assign boot_last  = (state == ST_BOOT) && out_ready && (addr == 6'(INIT_DEPTH - 1));
   assign init_addr  = addr;
   assign boot_done  = boot_done_r;
   assign resync_cnt = rs_cnt;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_WAIT;
      else     state <= state_nx;
   end

   // Next-state decode
   always_comb begin
      state_nx = state;
      unique case (state)
         ST_WAIT: if (delay_done) state_nx = (INIT_DEPTH == 0) ? ST_RUN : ST_BOOT;
         ST_BOOT: if (boot_last) state_nx = ST_RUN;
         ST_RUN:  state_nx = ST_RUN;
         default: state_nx = ST_WAIT;
      endcase
   end

   // Output decode: boot words straight from the table, packed words from the register
   always_comb begin
      in_ready  = 1'b0;
      out_valid = ovalid;
      out_data  = oreg;
      unique case (state)
         ST_BOOT: begin
            out_valid = 1'b1;
            out_data  = init_data;
         end
         ST_RUN:  in_ready = can_load & ~(held & ~is_rsw);
         default: in_ready = 1'b0;
      endcase
   end

   // A lone resync pattern is parked in 'held' until the next beat decides
   // whether it is a marker (dropped) or data (replayed via a flush cycle
   // that stalls the incoming beat for one clock).
   always_comb begin
      can_load  = ~ovalid | out_ready;
      is_rsw    = (in_data == RESYNC_WORD);
      accept    = in_valid & in_ready;
      flush     = (state == ST_RUN) & held & in_valid & ~is_rsw & can_load;
      resync    = accept & is_rsw & held;
      shift     = (accept & ~is_rsw) | flush;
      beat      = flush ? RESYNC_WORD : in_data;
      acc_nx    = (acc << IN_W) | OUT_W'(beat);
      word_done = shift & (beat_cnt == RATIO - 1);
      partial   = (beat_cnt != 0) | held;
   end

   // Boot sequencing: delay counter, table index, completion flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dly_cnt     <= '0;
         addr        <= '0;
         boot_done_r <= 1'b0;
      end else begin
         if (state == ST_WAIT) dly_cnt <= dly_cnt + 32'd1;
         if ((state == ST_BOOT) && out_ready && !boot_last) addr <= addr + 6'd1;
         if ((state != ST_RUN) && (state_nx == ST_RUN)) boot_done_r <= 1'b1;
      end
   end

   // Packing datapath: shift register, output register, resync tracking
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc      <= '0;
         oreg     <= '0;
         ovalid   <= 1'b0;
         beat_cnt <= '0;
         held     <= 1'b0;
         rs_cnt   <= '0;
      end else begin
         if (ovalid && out_ready) ovalid <= 1'b0;
         if (shift) begin
            acc <= acc_nx;
            if (word_done) begin
               oreg     <= acc_nx;
               ovalid   <= 1'b1;
               beat_cnt <= '0;
            end else begin
               beat_cnt <= beat_cnt + 32'd1;
            end
         end
         if (flush) held <= 1'b0;
         if (accept && is_rsw) begin
            if (resync) begin
               held     <= 1'b0;
               beat_cnt <= '0;
               if (rs_cnt != 8'hFF) rs_cnt <= rs_cnt + 8'd1;
            end else begin
               held <= 1'b1;
            end
         end
         if (drop) begin
            beat_cnt <= '0;
            held     <= 1'b0;
         end
      end
   end

`ifdef COM_RXPACK_TIMEOUT_EN
   logic [31:0] idle_cnt;
   logic [7:0]  dr_cnt;

   assign drop     = (state == ST_RUN) & partial & ~accept & ~flush & (idle_cnt == TIMEOUT - 1);
   assign drop_cnt = dr_cnt;

   // Idle watchdog for partial words
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idle_cnt <= '0;
         dr_cnt   <= '0;
      end else begin
         if (accept || flush || !partial || drop) idle_cnt <= '0;
         else                                     idle_cnt <= idle_cnt + 32'd1;
         if (drop && (dr_cnt != 8'hFF)) dr_cnt <= dr_cnt + 8'd1;
      end
   end
`else
   assign drop     = 1'b0;
   assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_pcileech_com_rx_packer.sv
// Bench for pcileech_com_rx_packer with its boot table alongside.
module tb_pcileech_com_rx_packer;

   localparam int unsigned IN_W       = 32;
   localparam int unsigned RATIO      = 2;
   localparam int unsigned OUT_W      = 64;
   localparam int unsigned INIT_DEPTH = 6;
   localparam int unsigned INIT_DELAY = 16;
`ifdef COM_RXPACK_TIMEOUT_EN
   localparam int unsigned TIMEOUT    = 8;
`else
   localparam int unsigned TIMEOUT    = 1024;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [IN_W-1:0]  in_data;
   logic             in_valid;
   logic             in_ready;
   logic [OUT_W-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic [5:0]       init_addr;
   logic [OUT_W-1:0] init_data;
   logic             boot_done;
   logic [7:0]       resync_cnt;
   logic [7:0]       drop_cnt;

   int               tests = 0;
   int               fails = 0;
   int               cyc   = 0;
   int               t0;
   logic [63:0]      sb[$];
   logic [63:0]      sb_exp;

   typedef struct {
      logic [31:0] b0;
      logic [31:0] b1;
      logic [63:0] exp;
   } vec_t;
   vec_t vec[4];

   pcileech_com_rx_packer #(
      .IN_W       (IN_W),
      .RATIO      (RATIO),
      .INIT_DEPTH (INIT_DEPTH),
      .INIT_DELAY (INIT_DELAY),
      .RESYNC_WORD(32'h66665555),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .init_addr (init_addr),
      .init_data (init_data),
      .boot_done (boot_done),
      .resync_cnt(resync_cnt),
      .drop_cnt  (drop_cnt)
   );

   pcileech_com_init_rom #(
      .OUT_W(OUT_W),
      .DEPTH(INIT_DEPTH)
   ) rom (
      .addr(init_addr),
      .data(init_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   // Scoreboard: every accepted output word must match the oldest expectation
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_unexpected: got %h, required no word", out_data);
         end else begin
            sb_exp = sb.pop_front();
            check("sb_word", out_data, sb_exp);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [31:0] d);
      int   n;
      logic rdy;
      in_valid = 1'b1;
      in_data  = d;
      n        = 0;
      rdy      = 1'b0;
      while (!rdy && n < 50) begin
         @(negedge clk);
         rdy = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!rdy) begin
         tests++;
         fails++;
         $display("FAIL beat_accept: got in_ready=0 for 50 cycles, required acceptance of %h", d);
      end
   endtask

   task automatic do_boot();
      for (int i = 0; i < 6; i++) sb.push_back(64'(i));
      rst = 1'b0;
      repeat (15) tick();
      check("boot_wait_valid", 64'(out_valid), 64'd0);
      check("boot_wait_ready", 64'(in_ready), 64'd0);
      tick();
      check("boot_first_valid", 64'(out_valid), 64'd1);
      check("boot_first_addr", 64'(init_addr), 64'd0);
      check("boot_done_early", 64'(boot_done), 64'd0);
      repeat (6) tick();
      check("boot_done", 64'(boot_done), 64'd1);
      check("run_in_ready", 64'(in_ready), 64'd1);
      check("run_out_valid", 64'(out_valid), 64'd0);
   endtask

   initial begin
      vec[0] = '{32'hAAAA0001, 32'hBBBB0002, 64'hAAAA0001_BBBB0002};
      vec[1] = '{32'h00000000, 32'hFFFFFFFF, 64'h00000000_FFFFFFFF};
      vec[2] = '{32'h66665555, 32'h12345678, 64'h66665555_12345678};
      vec[3] = '{32'hDEADBEEF, 32'h66665554, 64'hDEADBEEF_66665554};

      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      rst       = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", out_data, 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_init_addr", 64'(init_addr), 64'd0);
      check("rst_boot_done", 64'(boot_done), 64'd0);
      check("rst_resync_cnt", 64'(resync_cnt), 64'd0);
      check("rst_drop_cnt", 64'(drop_cnt), 64'd0);

      do_boot();

      // Table-driven two-beat words
      for (int i = 0; i < 4; i++) begin
         sb.push_back(vec[i].exp);
         send_beat(vec[i].b0);
         send_beat(vec[i].b1);
         in_valid = 1'b0;
         check("vec_valid", 64'(out_valid), 64'd1);
         check("vec_data", out_data, vec[i].exp);
         tick();
      end
      check("vec_resync_cnt", 64'(resync_cnt), 64'd0);

      // Back-to-back beats: no bubble with out_ready held high
      sb.push_back(64'h01020304_05060708);
      sb.push_back(64'h090A0B0C_0D0E0F10);
      t0 = cyc;
      send_beat(32'h01020304);
      send_beat(32'h05060708);
      send_beat(32'h090A0B0C);
      send_beat(32'h0D0E0F10);
      in_valid = 1'b0;
      check("stream_cycles", 64'(cyc - t0), 64'd4);
      tick();

      // Resync marker mid-word
      sb.push_back(64'h22222222_33333333);
      send_beat(32'h11111111);
      send_beat(32'h66665555);
      send_beat(32'h66665555);
      send_beat(32'h22222222);
      send_beat(32'h33333333);
      in_valid = 1'b0;
      check("resync_valid", 64'(out_valid), 64'd1);
      check("resync_data", out_data, 64'h22222222_33333333);
      check("resync_cnt", 64'(resync_cnt), 64'd1);
      tick();

      // Backpressure: full word held for 10 cycles
      out_ready = 1'b0;
      sb.push_back(64'hAAAA0003_BBBB0004);
      send_beat(32'hAAAA0003);
      send_beat(32'hBBBB0004);
      in_data = 32'hCCCC0005;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_in_ready", 64'(in_ready), 64'd0);
         check("bp_out_valid", 64'(out_valid), 64'd1);
         check("bp_out_data", out_data, 64'hAAAA0003_BBBB0004);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      t0 = cyc;
      send_beat(32'hCCCC0005);
      check("bp_drain_cycles", 64'(cyc - t0), 64'd1);
      sb.push_back(64'hCCCC0005_DDDD0006);
      send_beat(32'hDDDD0006);
      in_valid = 1'b0;
      check("bp_next_data", out_data, 64'hCCCC0005_DDDD0006);
      tick();

`ifdef COM_RXPACK_TIMEOUT_EN
      // Stale partial word discarded after TIMEOUT idle cycles
      send_beat(32'hEEEE0007);
      in_valid = 1'b0;
      repeat (7) tick();
      check("to_drop_early", 64'(drop_cnt), 64'd0);
      tick();
      check("to_drop_cnt", 64'(drop_cnt), 64'd1);
      sb.push_back(64'hF0F00008_0F0F0009);
      send_beat(32'hF0F00008);
      send_beat(32'h0F0F0009);
      in_valid = 1'b0;
      check("to_clean_data", out_data, 64'hF0F00008_0F0F0009);
      tick();
`else
      // Partial word survives a long idle gap
      send_beat(32'hEEEE0007);
      in_valid = 1'b0;
      repeat (20) tick();
      check("hold_drop_cnt", 64'(drop_cnt), 64'd0);
      check("hold_no_valid", 64'(out_valid), 64'd0);
      sb.push_back(64'hEEEE0007_F0F00008);
      send_beat(32'hF0F00008);
      in_valid = 1'b0;
      check("hold_data", out_data, 64'hEEEE0007_F0F00008);
      tick();
`endif

      // Reset during boot, then full replay
      rst = 1'b1;
      #1;
      check("rst2_resync_cnt", 64'(resync_cnt), 64'd0);
      check("rst2_out_data", out_data, 64'd0);
      tick();
      sb.push_back(64'd0);
      sb.push_back(64'd1);
      sb.push_back(64'd2);
      rst = 1'b0;
      repeat (16) tick();
      repeat (3) tick();
      check("midboot_addr", 64'(init_addr), 64'd3);
      rst = 1'b1;
      #1;
      check("midboot_rst_addr", 64'(init_addr), 64'd0);
      check("midboot_rst_valid", 64'(out_valid), 64'd0);
      check("midboot_rst_done", 64'(boot_done), 64'd0);
      tick();
      do_boot();

      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
